data_latch_array: RTL and testbench
===================================

Name: data_latch_array

Overview:
- Fully synchronous, parametrised serial-to-parallel capture block; next generation of the stage-shift data latch.
- After a start pulse it collects STAGE words from a valid/ready input stream into a shadow bank, then transfers the whole frame atomically to the parallel output bank.
- Features:
  - Optional continuous re-arm.
  - Abort.
  - Reversible slot order.
  - Frame counter.
  - Overrun flag.
- Sits between the sample source and the downstream counter/compare logic; cnt_clr replaces the old counter-reset tap.

Parameters:
- STAGE, 8, words per frame (>=2).
- DWIDTH, 8, bits per word.
- REVERSE, 0, 0: beat k -> slot k; 1: beat k -> slot STAGE-1-k.
- FCW, 16, frame_count width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a frame, sampled in IDLE only.
- abort  in  1  drop current frame, return to IDLE.
- cont_mode  in  1  1: re-arm automatically after each frame.
- in_valid  in  1  in_data valid.
- in_data  in  DWIDTH  input word.
- in_ready  out  1  block accepts a word this cycle.
- data_q  out  STAGE*DWIDTH  parallel frame; slot s at bits [s*DWIDTH +: DWIDTH].
- frame_done  out  1  one-cycle pulse, data_q just updated.
- cnt_clr  out  1  combinational pulse on the cycle the last word is accepted.
- busy  out  1  state != IDLE.
- fill_idx  out  $clog2(STAGE)  beat index of the next word.
- frame_count  out  FCW  completed frames, wraps modulo 2^FCW.
- overrun  out  1  sticky: start seen while busy.
- clr_err  in  1  clears overrun.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; fill_idx=0; data_q=0; shadow=0.
  - frame_done=0; frame_count=0; overrun=0.
  - rst has priority over every other input.
- FSM states:
  - IDLE:
    - in_ready=0.
    - start=1 -> CAPTURE, fill_idx=0.
  - CAPTURE:
    - in_ready=1.
    - A beat is in_valid&in_ready: write shadow[slot(fill_idx)] and increment fill_idx.
    - On a beat with fill_idx==STAGE-1 (cycle T):
      - cnt_clr=1 in cycle T.
      - At the closing edge, data_q <= shadow with the last word merged (all slots update together).
      - frame_done<=1, frame_count+1, fill_idx<=0, state -> DONE.
  - DONE:
    - Lasts exactly one cycle (T+1): frame_done=1, in_ready=0, beats ignored.
    - Next state: CAPTURE if cont_mode=1, else IDLE.
- Latency:
  - data_q and frame_done both become valid in the cycle after the last accepted beat.
  - data_q holds its value until the next frame completes.
- Gaps: in_valid=0 cycles stall capture indefinitely; there is no timeout.
- abort:
  - In CAPTURE or DONE: state -> IDLE, fill_idx=0, shadow discarded.
  - data_q and frame_count are unchanged.
  - abort on the same cycle as the final beat wins: no frame_done, no count, but cnt_clr still pulses combinationally.
- start while busy:
  - Ignored for control; sets overrun.
  - start in the DONE cycle also sets overrun.
  - clr_err=1 clears overrun. If start-while-busy and clr_err occur in the same cycle, set wins.
- Priority: rst > abort > beat/FSM transition.
- cont_mode is sampled only in DONE. Clearing it mid-frame lets the current frame finish and then return to IDLE.
- REVERSE only remaps the slot address; timing is identical.
- frame_count wraps to 0 after 2^FCW-1 with no flag.

Test Plan:
- Basic frame (STAGE=4, DWIDTH=8, REVERSE=0): start, then beats 0x11,0x22,0x33,0x44 back-to-back.
  - cnt_clr=1 on the 0x44 cycle.
  - Next cycle: frame_done=1, data_q=0x44332211, frame_count=1, state IDLE afterwards.
- Gapped input: same four words with in_valid low 3 cycles between beats.
  - Identical data_q.
  - frame_done exactly one cycle after the fourth beat.
  - data_q keeps its old value until then.
- REVERSE=1, same four beats -> data_q=0x11223344.
- Continuous mode: cont_mode=1, 8 beats 0x01..0x08.
  - Two frame_done pulses.
  - data_q=0x04030201, then 0x08070605.
  - The beat offered during DONE is not accepted (in_ready=0); frame_count=2.
- Abort: after 2 beats (0xAA,0xBB) assert abort.
  - busy=0, data_q unchanged from the prior frame, frame_count unchanged.
  - A new frame of 4 beats then completes normally with fill_idx starting at 0.
- Overrun and reset: start during CAPTURE -> overrun=1, capture unaffected.
  - clr_err -> overrun=0.
  - rst asserted mid-frame -> all outputs 0 on the next cycle, no frame_done.

Source files
------------

// File: rtl/data_latch_array_if.sv
// Stream, control and status bundle for the serial-to-parallel frame capture block.
// The master side offers words and commands. The slave side is the capture block itself.
interface data_latch_array_if #(
  parameter int STAGE  = 8,
  parameter int DWIDTH = 8,
  parameter int FCW    = 16
);
  localparam int IW = $clog2(STAGE);

  logic                    start;
  logic                    abort;
  logic                    cont_mode;
  logic                    in_valid;
  logic [DWIDTH-1:0]       in_data;
  logic                    clr_err;
  logic                    in_ready;
  logic [STAGE*DWIDTH-1:0] data_q;
  logic                    frame_done;
  logic                    cnt_clr;
  logic                    busy;
  logic [IW-1:0]           fill_idx;
  logic [FCW-1:0]          frame_count;
  logic                    overrun;

  modport master (
    output start, abort, cont_mode, in_valid, in_data, clr_err,
    input  in_ready, data_q, frame_done, cnt_clr, busy, fill_idx, frame_count, overrun
  );

  modport slave (
    input  start, abort, cont_mode, in_valid, in_data, clr_err,
    output in_ready, data_q, frame_done, cnt_clr, busy, fill_idx, frame_count, overrun
  );
endinterface

// File: rtl/data_latch_array.sv
// Collects STAGE words from a valid/ready stream into a shadow bank.
// The completed frame is then moved to the parallel output bank in a single edge.
module data_latch_array #(
  parameter int STAGE   = 8,
  parameter int DWIDTH  = 8,
  parameter int REVERSE = 0,
  parameter int FCW     = 16
) (
  input  logic                clk,
  input  logic                rst,
  data_latch_array_if.slave   bus
);
  localparam int IW = $clog2(STAGE);
  localparam logic [IW-1:0] LAST_IDX = IW'(STAGE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_t;
  typedef logic [STAGE-1:0][DWIDTH-1:0] bank_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  fill_idx_q, fill_idx_d;
  bank_t          shadow_q, shadow_d;
  bank_t          bank_q, bank_d;
  logic           frame_done_q, frame_done_d;
  logic [FCW-1:0] frame_count_q, frame_count_d;
  logic           overrun_q, overrun_d;
  logic           beat;
  logic           last_beat;
  logic [IW-1:0]  slot;

  function automatic logic [IW-1:0] slot_of(input logic [IW-1:0] idx);
    if (REVERSE != 0) return LAST_IDX - idx;
    return idx;
  endfunction

  assign beat      = (state_q == CAPTURE) && bus.in_valid;
  assign last_beat = beat && (fill_idx_q == LAST_IDX);
  assign slot      = slot_of(fill_idx_q);

  always_comb begin
    state_d       = state_q;
    fill_idx_d    = fill_idx_q;
    shadow_d      = shadow_q;
    bank_d        = bank_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;

    // A start that cannot be honoured outranks a simultaneous clear.
    if (bus.start && (state_q != IDLE)) overrun_d = 1'b1;
    else if (bus.clr_err)               overrun_d = 1'b0;

    if (bus.abort) begin
      state_d    = IDLE;
      fill_idx_d = '0;
      shadow_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d    = CAPTURE;
            fill_idx_d = '0;
          end
        end
        CAPTURE: begin
          if (beat) begin
            shadow_d[slot] = bus.in_data;
            if (last_beat) begin
              // Final word is merged so every output slot changes on the same edge.
              bank_d        = shadow_d;
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + FCW'(1);
              fill_idx_d    = '0;
              state_d       = DONE;
            end else begin
              fill_idx_d = fill_idx_q + IW'(1);
            end
          end
        end
        DONE:    state_d = bus.cont_mode ? CAPTURE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fill_idx_q    <= '0;
      shadow_q      <= '0;
      bank_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_idx_q    <= fill_idx_d;
      shadow_q      <= shadow_d;
      bank_q        <= bank_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.in_ready    = (state_q == CAPTURE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.cnt_clr     = last_beat;
  assign bus.data_q      = bank_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.fill_idx    = fill_idx_q;
  assign bus.frame_count = frame_count_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_data_latch_array.sv
// Bench for data_latch_array: forward and reversed instances share one stimulus stream.
// Both instances are compared with a queue-based frame model every cycle.
module tb_data_latch_array;
  localparam int STAGE = 4;
  localparam int DW    = 8;
  localparam int FCW   = 16;
  localparam int FCW_R = 3;

  typedef struct {
    logic       rst, start, abort, cont, valid, clr;
    logic [7:0] data;
  } in_t;

  typedef struct {
    in_t         stim;
    logic        rdy, cclr, busy, fd;
    logic [31:0] dq, dqr;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_latch_array_if #(.STAGE(STAGE), .DWIDTH(DW), .FCW(FCW))   bus_f ();
  data_latch_array_if #(.STAGE(STAGE), .DWIDTH(DW), .FCW(FCW_R)) bus_r ();

  assign bus_r.start     = bus_f.start;
  assign bus_r.abort     = bus_f.abort;
  assign bus_r.cont_mode = bus_f.cont_mode;
  assign bus_r.in_valid  = bus_f.in_valid;
  assign bus_r.in_data   = bus_f.in_data;
  assign bus_r.clr_err   = bus_f.clr_err;

  data_latch_array #(.STAGE(STAGE), .DWIDTH(DW), .REVERSE(0), .FCW(FCW))
    dut_f (.clk(clk), .rst(rst), .bus(bus_f));
  data_latch_array #(.STAGE(STAGE), .DWIDTH(DW), .REVERSE(1), .FCW(FCW_R))
    dut_r (.clk(clk), .rst(rst), .bus(bus_r));

  int n_chk  = 0;
  int n_fail = 0;

  // Frame model: a capture flag, a one-cycle completion flag and the words gathered so far.
  bit          m_capt, m_done, m_ovr;
  logic [7:0]  m_words[$];
  logic [31:0] m_dq, m_dqr;
  int          m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic r, input logic s, input logic a, input logic c,
                             input logic v, input logic [7:0] d, input logic ce);
    in_t t;
    t.rst = r; t.start = s; t.abort = a; t.cont = c; t.valid = v; t.data = d; t.clr = ce;
    return t;
  endfunction

  task automatic check_model();
    logic exp_clr;
    exp_clr = m_capt && bus_f.in_valid && (m_words.size() == STAGE - 1);
    chk("in_ready",    bus_f.in_ready,    m_capt);
    chk("busy",        bus_f.busy,        m_capt || m_done);
    chk("frame_done",  bus_f.frame_done,  m_done);
    chk("cnt_clr",     bus_f.cnt_clr,     exp_clr);
    chk("fill_idx",    bus_f.fill_idx,    m_words.size());
    chk("data_q",      bus_f.data_q,      m_dq);
    chk("frame_count", bus_f.frame_count, m_cnt % 65536);
    chk("overrun",     bus_f.overrun,     m_ovr);
    chk("rev_cnt_clr", bus_r.cnt_clr,     exp_clr);
    chk("rev_data_q",  bus_r.data_q,      m_dqr);
    chk("rev_count",   bus_r.frame_count, m_cnt % 8);
    chk("rev_done",    bus_r.frame_done,  m_done);
  endtask

  task automatic model_step();
    if (rst) begin
      m_capt = 0; m_done = 0; m_ovr = 0; m_words.delete();
      m_dq = '0; m_dqr = '0; m_cnt = 0;
      return;
    end
    if (bus_f.start && (m_capt || m_done)) m_ovr = 1;
    else if (bus_f.clr_err)                m_ovr = 0;
    if (bus_f.abort) begin
      m_capt = 0; m_done = 0; m_words.delete();
    end else if (m_done) begin
      m_done = 0;
      m_capt = bus_f.cont_mode;
    end else if (m_capt) begin
      if (bus_f.in_valid) begin
        m_words.push_back(bus_f.in_data);
        if (m_words.size() == STAGE) begin
          for (int k = 0; k < STAGE; k++) begin
            m_dq[k*8 +: 8]             = m_words[k];
            m_dqr[(STAGE-1-k)*8 +: 8]  = m_words[k];
          end
          m_cnt++;
          m_capt = 0; m_done = 1; m_words.delete();
        end
      end
    end else if (bus_f.start) begin
      m_capt = 1;
    end
  endtask

  task automatic cycle(input in_t s);
    @(posedge clk);
    #1;
    rst             = s.rst;
    bus_f.start     = s.start;
    bus_f.abort     = s.abort;
    bus_f.cont_mode = s.cont;
    bus_f.in_valid  = s.valid;
    bus_f.in_data   = s.data;
    bus_f.clr_err   = s.clr;
    @(negedge clk);
    check_model();
    model_step();
  endtask

  task automatic beat(input logic [7:0] d, input logic c);
    cycle(mk(0, 0, 0, c, 1, d, 0));
  endtask

  task automatic idle(input logic c);
    cycle(mk(0, 0, 0, c, 0, 8'h00, 0));
  endtask

  vec_t tbl[7];

  initial begin
    rst = 1'b1;
    bus_f.start = 0; bus_f.abort = 0; bus_f.cont_mode = 0;
    bus_f.in_valid = 0; bus_f.in_data = '0; bus_f.clr_err = 0;
    m_capt = 0; m_done = 0; m_ovr = 0; m_dq = '0; m_dqr = '0; m_cnt = 0;

    // Reset state
    cycle(mk(1, 0, 0, 0, 0, 8'h00, 0));
    cycle(mk(1, 1, 0, 0, 1, 8'h5A, 0));
    chk("rst_busy",  bus_f.busy, 0);
    chk("rst_dq",    bus_f.data_q, 0);
    chk("rst_count", bus_f.frame_count, 0);

    // Basic frame, table driven
    tbl[0] = '{mk(0,1,0,0,0,8'h00,0), 0,0,0,0, 32'h0,        32'h0,        16'd0};
    tbl[1] = '{mk(0,0,0,0,1,8'h11,0), 1,0,1,0, 32'h0,        32'h0,        16'd0};
    tbl[2] = '{mk(0,0,0,0,1,8'h22,0), 1,0,1,0, 32'h0,        32'h0,        16'd0};
    tbl[3] = '{mk(0,0,0,0,1,8'h33,0), 1,0,1,0, 32'h0,        32'h0,        16'd0};
    tbl[4] = '{mk(0,0,0,0,1,8'h44,0), 1,1,1,0, 32'h0,        32'h0,        16'd0};
    tbl[5] = '{mk(0,0,0,0,0,8'h00,0), 0,0,1,1, 32'h44332211, 32'h11223344, 16'd1};
    tbl[6] = '{mk(0,0,0,0,0,8'h00,0), 0,0,0,0, 32'h44332211, 32'h11223344, 16'd1};
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].stim);
      chk($sformatf("tbl%0d_rdy", i),  bus_f.in_ready,    tbl[i].rdy);
      chk($sformatf("tbl%0d_clr", i),  bus_f.cnt_clr,     tbl[i].cclr);
      chk($sformatf("tbl%0d_busy", i), bus_f.busy,        tbl[i].busy);
      chk($sformatf("tbl%0d_fd", i),   bus_f.frame_done,  tbl[i].fd);
      chk($sformatf("tbl%0d_dq", i),   bus_f.data_q,      tbl[i].dq);
      chk($sformatf("tbl%0d_dqr", i),  bus_r.data_q,      tbl[i].dqr);
      chk($sformatf("tbl%0d_cnt", i),  bus_f.frame_count, tbl[i].cnt);
    end

    // Gapped input
    cycle(mk(0, 1, 0, 0, 0, 8'h00, 0));
    for (int w = 1; w <= 4; w++) begin
      if (w > 1) for (int g = 0; g < 3; g++) idle(0);
      beat(8'(w * 8'h11), 0);
    end
    chk("gap_fd_early", bus_f.frame_done, 0);
    idle(0);
    chk("gap_fd", bus_f.frame_done, 1);
    chk("gap_dq", bus_f.data_q, 32'h44332211);
    chk("gap_cnt", bus_f.frame_count, 2);
    idle(0);
    chk("gap_fd_off", bus_f.frame_done, 0);

    // Continuous mode
    cycle(mk(0, 1, 0, 1, 0, 8'h00, 0));
    for (int w = 1; w <= 4; w++) beat(8'(w), 1);
    beat(8'h05, 1);
    chk("cont_done_rdy", bus_f.in_ready, 0);
    chk("cont_fd1", bus_f.frame_done, 1);
    chk("cont_dq1", bus_f.data_q, 32'h04030201);
    for (int w = 5; w <= 8; w++) beat(8'(w), 1);
    idle(0);
    chk("cont_fd2", bus_f.frame_done, 1);
    chk("cont_dq2", bus_f.data_q, 32'h08070605);
    chk("cont_cnt", bus_f.frame_count, 4);
    idle(0);
    chk("cont_idle", bus_f.busy, 0);

    // Abort after two beats, then a clean frame
    cycle(mk(0, 1, 0, 0, 0, 8'h00, 0));
    beat(8'hAA, 0);
    beat(8'hBB, 0);
    cycle(mk(0, 0, 1, 0, 0, 8'h00, 0));
    idle(0);
    chk("abort_busy", bus_f.busy, 0);
    chk("abort_dq", bus_f.data_q, 32'h08070605);
    chk("abort_cnt", bus_f.frame_count, 4);
    cycle(mk(0, 1, 0, 0, 0, 8'h00, 0));
    idle(0);
    chk("abort_fill0", bus_f.fill_idx, 0);
    beat(8'h5A, 0); beat(8'h6B, 0); beat(8'h7C, 0); beat(8'h8D, 0);
    idle(0);
    chk("post_abort_dq", bus_f.data_q, 32'h8D7C6B5A);
    chk("post_abort_cnt", bus_f.frame_count, 5);

    // Abort on the final beat
    cycle(mk(0, 1, 0, 0, 0, 8'h00, 0));
    beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0);
    cycle(mk(0, 0, 1, 0, 1, 8'h04, 0));
    chk("abort_last_clr", bus_f.cnt_clr, 1);
    idle(0);
    chk("abort_last_fd", bus_f.frame_done, 0);
    chk("abort_last_cnt", bus_f.frame_count, 5);

    // Overrun, clear, set-beats-clear, reset mid-frame
    cycle(mk(0, 1, 0, 0, 0, 8'h00, 0));
    beat(8'h01, 0);
    cycle(mk(0, 1, 0, 0, 1, 8'h02, 0));
    beat(8'h03, 0);
    chk("ovr_set", bus_f.overrun, 1);
    beat(8'h04, 0);
    idle(0);
    chk("ovr_dq", bus_f.data_q, 32'h04030201);
    cycle(mk(0, 0, 0, 0, 0, 8'h00, 1));
    idle(0);
    chk("ovr_clr", bus_f.overrun, 0);
    cycle(mk(0, 1, 0, 0, 0, 8'h00, 0));
    cycle(mk(0, 1, 0, 0, 1, 8'hC1, 1));
    beat(8'hC2, 0);
    chk("ovr_set_wins", bus_f.overrun, 1);
    cycle(mk(1, 0, 0, 0, 1, 8'hC3, 0));
    idle(0);
    chk("rst_mid_busy", bus_f.busy, 0);
    chk("rst_mid_fd", bus_f.frame_done, 0);
    chk("rst_mid_dq", bus_f.data_q, 0);
    chk("rst_mid_cnt", bus_f.frame_count, 0);
    chk("rst_mid_ovr", bus_f.overrun, 0);
    chk("rst_mid_fill", bus_f.fill_idx, 0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      in_t s;
      s.rst   = ($urandom_range(0, 199) == 0);
      s.abort = ($urandom_range(0, 49) == 0);
      s.start = ($urandom_range(0, 5) == 0);
      s.clr   = ($urandom_range(0, 19) == 0);
      s.cont  = ($urandom_range(0, 1) == 1);
      s.valid = ($urandom_range(0, 9) < 7);
      s.data  = 8'($urandom);
      cycle(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
